// File: rtl/lp5_feature_accumulator.sv
// Thresholded event accumulator into a saturating feature map; 2-cycle read-modify-write per event, 1 event/cycle sustained.
// Backpressure: ready drops when the input FIFO is full or outside RUN; host reads stall the FIFO pop for that cycle.
module lp5_feature_accumulator #(
  parameter int DATA_WIDTH   = 4,
  parameter int DATA_WIDTH_2 = DATA_WIDTH + 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int ACC_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int THRESHOLD    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH_2-1:0] in_event_value,
  input  logic [ADDR_WIDTH-1:0]   in_event_addr,
  input  logic                    in_event_valid,
  output logic                    ready_for_new_event,
  input  logic                    clear_req,
  output logic                    busy,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [ACC_WIDTH-1:0]    rd_data,
  output logic                    rd_valid,
  output logic [31:0]             event_count,
  output logic [31:0]             drop_count,
  output logic                    overflow_flag
);

  localparam int FP_W  = $clog2(FIFO_DEPTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {S_CLEAR, S_RUN, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [DATA_WIDTH_2-1:0] r_fifo_val  [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [FP_W:0]           r_wr_ptr, r_rd_ptr;
  logic [FP_W:0]           w_fifo_cnt;
  logic                    w_fifo_full, w_fifo_empty;

  logic [ACC_WIDTH-1:0]    r_map [DEPTH];
  logic [ACC_WIDTH-1:0]    r_rd_q;
  logic                    r_rd_vld;
  logic [ADDR_WIDTH-1:0]   r_sweep;

  logic                    r_s1_vld;
  logic [ADDR_WIDTH-1:0]   r_s1_addr;
  logic [DATA_WIDTH_2-1:0] r_s1_val;
  logic                    r_fwd_vld;
  logic [ADDR_WIDTH-1:0]   r_fwd_addr;
  logic [ACC_WIDTH-1:0]    r_fwd_data;

  logic [31:0]             r_event_cnt, r_drop_cnt;
  logic                    r_ovf;

  logic [DATA_WIDTH_2-1:0] w_abs;
  logic                    w_below, w_accept, w_push, w_drop, w_pop;
  logic [ADDR_WIDTH-1:0]   w_raddr, w_waddr;
  logic                    w_we;
  logic [ACC_WIDTH-1:0]    w_wdata, w_old, w_sat;
  logic [ACC_WIDTH:0]      w_sum;

  assign w_fifo_cnt   = r_wr_ptr - r_rd_ptr;
  assign w_fifo_full  = (w_fifo_cnt == (FP_W+1)'(FIFO_DEPTH));
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);

  assign ready_for_new_event = (r_state == S_RUN) && !w_fifo_full;
  assign busy                = (r_state != S_RUN);

  // -128 negates to 0x80, which still reads correctly as an unsigned magnitude
  assign w_abs    = in_event_value[DATA_WIDTH_2-1] ? -in_event_value : in_event_value;
  assign w_below  = (w_abs < DATA_WIDTH_2'(THRESHOLD));
  assign w_accept = in_event_valid && ready_for_new_event;
  assign w_push   = w_accept && !w_below;
  assign w_drop   = w_accept && w_below;
  assign w_pop    = (r_state != S_CLEAR) && !w_fifo_empty && !rd_en;

  assign w_raddr  = rd_en ? rd_addr : r_fifo_addr[r_rd_ptr[FP_W-1:0]];

  // The RAM read in S0 misses a write landing in the same cycle; replay it here
  assign w_old = (r_fwd_vld && (r_fwd_addr == r_s1_addr)) ? r_fwd_data : r_rd_q;
  assign w_sum = {w_old[ACC_WIDTH-1], w_old}
               + {{(ACC_WIDTH+1-DATA_WIDTH_2){r_s1_val[DATA_WIDTH_2-1]}}, r_s1_val};

  always_comb begin
    w_sat = w_sum[ACC_WIDTH-1:0];
    if (w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1])
      w_sat = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_s1_addr;
    w_wdata = w_sat;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_sweep;
      w_wdata = '0;
    end else if (r_s1_vld) begin
      w_we = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_sweep == '1) w_state_nxt = S_RUN;
      S_RUN:   if (clear_req) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_fifo_empty && !r_s1_vld) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLEAR;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_val[r_wr_ptr[FP_W-1:0]]  <= in_event_value;
      r_fifo_addr[r_wr_ptr[FP_W-1:0]] <= in_event_addr;
    end
    if (w_we) r_map[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_sweep     <= '0;
      r_rd_q      <= '0;
      r_rd_vld    <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1_addr   <= '0;
      r_s1_val    <= '0;
      r_fwd_vld   <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
      r_event_cnt <= '0;
      r_drop_cnt  <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_sweep    <= (r_state == S_CLEAR) ? r_sweep + 1'b1 : '0;
      r_rd_q     <= r_map[w_raddr];
      r_rd_vld   <= rd_en;
      r_s1_vld   <= w_pop;
      r_s1_addr  <= r_fifo_addr[r_rd_ptr[FP_W-1:0]];
      r_s1_val   <= r_fifo_val[r_rd_ptr[FP_W-1:0]];
      r_fwd_vld  <= w_we;
      r_fwd_addr <= w_waddr;
      r_fwd_data <= w_wdata;
      if (r_s1_vld && r_state != S_CLEAR) r_event_cnt <= r_event_cnt + 1'b1;
      if (w_drop) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (in_event_valid && !ready_for_new_event) r_ovf <= 1'b1;
    end
  end

  assign rd_data       = r_rd_q;
  assign rd_valid      = r_rd_vld;
  assign event_count   = r_event_cnt;
  assign drop_count    = r_drop_cnt;
  assign overflow_flag = r_ovf;

endmodule
